// File: rtl/cache_pkg.sv
// cache_pkg: shared FSM state type, address-field slicing and merge helpers for set_assoc_wb_cache
package cache_pkg;
  typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND} cache_state_t;
  localparam int ADDR_W = 32;
  localparam int WORD_W = 32;
  localparam int WORD_BYTES = WORD_W / 8;
  function automatic logic [ADDR_W-1:0] addr_tag(input logic [ADDR_W-1:0] a, input int ob, input int ib);
    return a >> (ob + ib);
  endfunction
  function automatic logic [ADDR_W-1:0] addr_index(input logic [ADDR_W-1:0] a, input int ob);
    return a >> ob;
  endfunction
  function automatic logic [ADDR_W-1:0] addr_word(input logic [ADDR_W-1:0] a);
    return a >> 2;
  endfunction
  function automatic logic [WORD_W-1:0] merge_word(input logic [WORD_W-1:0] old_w, input logic [WORD_W-1:0] new_w,
                                                   input logic [WORD_BYTES-1:0] be);
    logic [WORD_W-1:0] r;
    for (int b = 0; b < WORD_BYTES; b++) r[b*8 +: 8] = be[b] ? new_w[b*8 +: 8] : old_w[b*8 +: 8];
    return r;
  endfunction
endpackage

// File: rtl/lru_age_tracker.sv
// lru_age_tracker: per-set true-LRU age counters; picks lowest invalid way, else the oldest way
// ports: clk_i/rst_i, upd_i strobe with set_i/way_i access, valid_i of set_i, victim_o, all_valid_o
module lru_age_tracker #(
  parameter int NB_WAYS = 4,
  parameter int IndexBits = 5,
  localparam int BitsWays = $clog2(NB_WAYS)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 upd_i,
  input  logic [IndexBits-1:0] set_i,
  input  logic [BitsWays-1:0]  way_i,
  input  logic [NB_WAYS-1:0]   valid_i,
  output logic [BitsWays-1:0]  victim_o,
  output logic                 all_valid_o
);
  logic [BitsWays-1:0] age_q [2**IndexBits][NB_WAYS];
  logic [BitsWays-1:0] age_d [2**IndexBits][NB_WAYS];
  always_comb begin
    age_d = age_q;
    for (int w = 0; w < NB_WAYS; w++)
      if (upd_i && age_q[set_i][w] < age_q[set_i][way_i]) age_d[set_i][w] = age_q[set_i][w] + 1'b1;
    if (upd_i) age_d[set_i][way_i] = '0;
    victim_o = '0;
    for (int w = 0; w < NB_WAYS; w++)
      if (age_q[set_i][w] == BitsWays'(NB_WAYS - 1)) victim_o = BitsWays'(w);
    for (int w = NB_WAYS - 1; w >= 0; w--)
      if (!valid_i[w]) victim_o = BitsWays'(w);
  end
  assign all_valid_o = &valid_i;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      for (int s = 0; s < 2**IndexBits; s++)
        for (int w = 0; w < NB_WAYS; w++) age_q[s][w] <= BitsWays'(w);
    end else begin
      age_q <= age_d;
    end
endmodule

// File: rtl/set_assoc_wb_cache.sv
// set_assoc_wb_cache: N-way write-back/write-allocate data cache with byte-enabled stores and LRU
// ports: req_* handshake from the LSU, resp_* one-cycle completion, mem_* line-wide refill/write-back, stat_* hit/miss pulses
module set_assoc_wb_cache
  import cache_pkg::*;
#(
  parameter int ByteOffsetBits = 5,
  parameter int IndexBits = 5,
  parameter int TagBits = 22,
  parameter int NB_WAYS = 4,
  localparam int BITS_WAYS = $clog2(NB_WAYS),
  localparam int NrWordsPerLine = 2**ByteOffsetBits / 4,
  localparam int LineSize = 32 * NrWordsPerLine
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_we_i,
  input  logic [31:0]         req_addr_i,
  input  logic [31:0]         req_wdata_i,
  input  logic [3:0]          req_be_i,
  output logic                resp_valid_o,
  output logic [31:0]         resp_rdata_o,
  output logic [31:0]         mem_addr_o,
  output logic                mem_read_en_o,
  input  logic                mem_read_valid_i,
  input  logic [LineSize-1:0] mem_read_data_i,
  output logic                mem_write_en_o,
  output logic [LineSize-1:0] mem_write_data_o,
  input  logic                mem_write_done_i,
  output logic                stat_hit_o,
  output logic                stat_miss_o
);
  localparam int NrSets = 2**IndexBits;
  localparam int OffW = ByteOffsetBits - 2;
  cache_state_t state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, maddr_q, maddr_d;
  logic we_q, we_d, ready_q, ready_d, resp_q, resp_d, hit_q, hit_d, miss_q, miss_d, rd_q, rd_d, wr_q, wr_d;
  logic [3:0] be_q, be_d;
  logic [BITS_WAYS-1:0] victim_q, victim_d, hit_way, mem_way, lru_victim;
  logic [NrSets-1:0][NB_WAYS-1:0] valid_q, valid_d, dirty_q, dirty_d;
  logic [LineSize-1:0] wb_q, wb_d, fill_src, merged;
  logic [TagBits-1:0] tag_mem [NrSets][NB_WAYS];
  logic [LineSize-1:0] data_mem [NrSets][NB_WAYS];
  logic [TagBits-1:0] req_tag;
  logic [IndexBits-1:0] req_idx;
  logic [OffW-1:0] req_off;
  logic hit, mem_we, lru_upd, all_valid;
  assign req_tag = TagBits'(addr_tag(addr_q, ByteOffsetBits, IndexBits));
  assign req_idx = IndexBits'(addr_index(addr_q, ByteOffsetBits));
  assign req_off = OffW'(addr_word(addr_q));
  lru_age_tracker #(.NB_WAYS(NB_WAYS), .IndexBits(IndexBits)) u_lru (
    .clk_i, .rst_i, .upd_i(lru_upd), .set_i(req_idx), .way_i(mem_way),
    .valid_i(valid_q[req_idx]), .victim_o(lru_victim), .all_valid_o(all_valid)
  );
  always_comb begin
    state_d = state_q;
    {addr_d, wdata_d, we_d, be_d, victim_d} = {addr_q, wdata_q, we_q, be_q, victim_q};
    {valid_d, dirty_d, wb_d, maddr_d, rdata_d} = {valid_q, dirty_q, wb_q, maddr_q, rdata_q};
    {ready_d, rd_d, wr_d} = {ready_q, rd_q, wr_q};
    {resp_d, hit_d, miss_d, mem_we, lru_upd} = '0;
    hit = 1'b0;
    hit_way = '0;
    for (int w = NB_WAYS - 1; w >= 0; w--)
      if (valid_q[req_idx][w] && tag_mem[req_idx][w] == req_tag) {hit, hit_way} = {1'b1, BITS_WAYS'(w)};
    // the same merge path serves a store hit (old line) and a store refill (incoming line)
    mem_way = state_q == REFILL ? victim_q : hit_way;
    fill_src = state_q == REFILL ? mem_read_data_i : data_mem[req_idx][hit_way];
    merged = fill_src;
    merged[req_off*32 +: 32] = merge_word(fill_src[req_off*32 +: 32], wdata_q, be_q);
    case (state_q)
      IDLE: if (req_valid_i) begin
        {addr_d, wdata_d, we_d, be_d} = {req_addr_i, req_wdata_i, req_we_i, req_be_i};
        {ready_d, state_d} = {1'b0, LOOKUP};
      end
      LOOKUP: if (hit) begin
        {lru_upd, mem_we, resp_d, hit_d, state_d} = {1'b1, we_q, 1'b1, 1'b1, RESPOND};
        if (we_q) dirty_d[req_idx][hit_way] = 1'b1;
        rdata_d = we_q ? '0 : fill_src[req_off*32 +: 32];
      end else begin
        victim_d = lru_victim;
        if (all_valid && dirty_q[req_idx][lru_victim]) begin
          {wr_d, state_d, wb_d} = {1'b1, WRITEBACK, data_mem[req_idx][lru_victim]};
          maddr_d = {tag_mem[req_idx][lru_victim], req_idx, {ByteOffsetBits{1'b0}}};
        end else begin
          {rd_d, state_d} = {1'b1, REFILL};
          maddr_d = {req_tag, req_idx, {ByteOffsetBits{1'b0}}};
        end
      end
      WRITEBACK: if (mem_write_done_i) begin
        dirty_d[req_idx][victim_q] = 1'b0;
        {wr_d, rd_d, state_d} = {1'b0, 1'b1, REFILL};
        maddr_d = {req_tag, req_idx, {ByteOffsetBits{1'b0}}};
      end
      REFILL: if (mem_read_valid_i) begin
        {valid_d[req_idx][victim_q], dirty_d[req_idx][victim_q]} = {1'b1, we_q};
        {mem_we, lru_upd, rd_d, maddr_d} = {1'b1, 1'b1, 1'b0, 32'h0};
        {resp_d, miss_d, state_d} = {1'b1, 1'b1, RESPOND};
        rdata_d = we_q ? '0 : mem_read_data_i[req_off*32 +: 32];
      end
      RESPOND: {ready_d, state_d} = {1'b1, IDLE};
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q <= IDLE;
      {addr_q, wdata_q, we_q, be_q, victim_q} <= '0;
      {valid_q, dirty_q, wb_q, maddr_q, rdata_q} <= '0;
      {rd_q, wr_q, resp_q, hit_q, miss_q} <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      {addr_q, wdata_q, we_q, be_q, victim_q} <= {addr_d, wdata_d, we_d, be_d, victim_d};
      {valid_q, dirty_q, wb_q, maddr_q, rdata_q} <= {valid_d, dirty_d, wb_d, maddr_d, rdata_d};
      {rd_q, wr_q, resp_q, hit_q, miss_q, ready_q} <= {rd_d, wr_d, resp_d, hit_d, miss_d, ready_d};
    end
  always_ff @(posedge clk_i)
    if (mem_we) begin
      data_mem[req_idx][mem_way] <= we_q ? merged : fill_src;
      tag_mem[req_idx][mem_way] <= req_tag;
    end
  assign {req_ready_o, resp_valid_o, resp_rdata_o, stat_hit_o, stat_miss_o} = {ready_q, resp_q, rdata_q, hit_q, miss_q};
  assign {mem_addr_o, mem_read_en_o, mem_write_en_o, mem_write_data_o} = {maddr_q, rd_q, wr_q, wb_q};
endmodule

// File: tb/tb_set_assoc_wb_cache.sv
// tb_set_assoc_wb_cache: directed self-checking bench for set_assoc_wb_cache
module tb_set_assoc_wb_cache;
  logic clk = 1'b0, rst = 1'b0;
  logic req_valid_i = 0, req_ready_o, req_we_i = 0, resp_valid_o, mem_read_en_o, mem_read_valid_i = 0;
  logic mem_write_en_o, mem_write_done_i = 0, stat_hit_o, stat_miss_o;
  logic [31:0] req_addr_i = 0, req_wdata_i = 0, resp_rdata_o, mem_addr_o;
  logic [3:0] req_be_i = 0;
  logic [255:0] mem_read_data_i = '0, mem_write_data_o;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  set_assoc_wb_cache dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_be_i(req_be_i), .resp_valid_o(resp_valid_o),
    .resp_rdata_o(resp_rdata_o), .mem_addr_o(mem_addr_o), .mem_read_en_o(mem_read_en_o),
    .mem_read_valid_i(mem_read_valid_i), .mem_read_data_i(mem_read_data_i), .mem_write_en_o(mem_write_en_o),
    .mem_write_data_o(mem_write_data_o), .mem_write_done_i(mem_write_done_i), .stat_hit_o(stat_hit_o),
    .stat_miss_o(stat_miss_o)
  );
  function automatic logic [255:0] mk_line(input logic [31:0] a);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = {a[31:5], 5'b0} ^ (i << 2) ^ 32'hA500_0000;
    return l;
  endfunction
  function automatic logic [31:0] exp_word(input logic [31:0] a);
    return {a[31:2], 2'b0} ^ 32'hA500_0000;
  endfunction
  task automatic apply_reset();
    {req_valid_i, mem_read_valid_i, mem_write_done_i} = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic send(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    @(negedge clk);
    {req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i} = {1'b1, we, a, wd, be};
    @(negedge clk);
    {req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i} = {1'b0, ~we, 32'hFFFF_FFFC, $urandom, 4'hF};
  endtask
  task automatic wait_sig(input int which, output bit ok, output int n);
    ok = 0;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      if ((which == 0 && mem_read_en_o) || (which == 1 && mem_write_en_o) || (which == 2 && resp_valid_o)) begin
        ok = 1;
        return;
      end
      @(negedge clk);
      n++;
    end
  endtask
  task automatic serve_read(input logic [255:0] l);
    {mem_read_data_i, mem_read_valid_i} = {l, 1'b1};
    @(negedge clk);
    mem_read_valid_i = 1'b0;
  endtask
  task automatic miss_txn(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                          output bit ok, output logic [31:0] maddr, output logic [31:0] rdata);
    bit o1, o2;
    int n;
    send(we, a, wd, be);
    wait_sig(0, o1, n);
    maddr = mem_addr_o;
    ok = o1 && !mem_write_en_o;
    if (o1) serve_read(mk_line(a));
    wait_sig(2, o2, n);
    rdata = resp_rdata_o;
    ok = ok && o2 && stat_miss_o && !stat_hit_o;
  endtask
  task automatic hit_txn(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                         output bit ok, output int n, output logic [31:0] rdata);
    bit o;
    send(we, a, wd, be);
    wait_sig(2, o, n);
    rdata = resp_rdata_o;
    ok = o && stat_hit_o && !stat_miss_o && !mem_read_en_o && !mem_write_en_o;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++;
    if ({resp_valid_o, mem_read_en_o, mem_write_en_o, stat_hit_o, stat_miss_o} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 00000", {resp_valid_o, mem_read_en_o, mem_write_en_o, stat_hit_o, stat_miss_o});
    end
    apply_reset();
    @(negedge clk);
    checks++;
    if (req_ready_o !== 1'b1 || mem_addr_o !== 32'h0 || resp_rdata_o !== 32'h0 || mem_write_data_o !== '0) begin
      errors++;
      $display("FAIL reset_data: ready %b addr %h rdata %h want 1/0/0", req_ready_o, mem_addr_o, resp_rdata_o);
    end
  endtask
  task automatic test_cold_miss();
    bit o;
    int n;
    logic [255:0] l;
    send(1'b0, 32'h4, 32'h0, 4'h0);
    wait_sig(0, o, n);
    checks++;
    if (!o || mem_addr_o !== 32'h0 || mem_write_en_o !== 1'b0) begin
      errors++;
      $display("FAIL cold_refill_req: seen %b addr %h wr %b want 1/00000000/0", o, mem_addr_o, mem_write_en_o);
    end
    l = mk_line(32'h0);
    l[63:32] = 32'hDEAD_BEEF;
    serve_read(l);
    wait_sig(2, o, n);
    checks++;
    if (!o || resp_rdata_o !== 32'hDEAD_BEEF || stat_miss_o !== 1'b1 || stat_hit_o !== 1'b0) begin
      errors++;
      $display("FAIL cold_resp: seen %b rdata %h miss %b want 1/deadbeef/1", o, resp_rdata_o, stat_miss_o);
    end
  endtask
  task automatic test_hit_and_store();
    bit o;
    int n;
    logic [31:0] d;
    hit_txn(1'b0, 32'h4, 32'h0, 4'h0, o, n, d);
    checks++;
    if (!o || n !== 1 || d !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL load_hit: ok %b lat %0d rdata %h want 1/1/deadbeef", o, n, d);
    end
    hit_txn(1'b1, 32'h4, 32'h1122_3344, 4'b0011, o, n, d);
    checks++;
    if (!o || n !== 1 || d !== 32'h0) begin
      errors++;
      $display("FAIL store_hit: ok %b lat %0d rdata %h want 1/1/00000000", o, n, d);
    end
    hit_txn(1'b0, 32'h4, 32'h0, 4'h0, o, n, d);
    checks++;
    if (!o || d !== 32'hDEAD_3344) begin
      errors++;
      $display("FAIL store_merge: ok %b rdata %h want 1/dead3344", o, d);
    end
  endtask
  task automatic test_lru();
    bit o;
    int n;
    logic [31:0] ma, d;
    apply_reset();
    for (int t = 0; t < 4; t++) begin
      miss_txn(1'b0, 32'h400 * t + 32'h8, 32'h0, 4'h0, o, ma, d);
      checks++;
      if (!o || ma !== 32'h400 * t || d !== exp_word(32'h400 * t + 32'h8)) begin
        errors++;
        $display("FAIL lru_fill%0d: ok %b addr %h rdata %h want 1/%h/%h", t, o, ma, d, 32'h400 * t, exp_word(32'h400 * t + 32'h8));
      end
    end
    hit_txn(1'b0, 32'h0, 32'h0, 4'h0, o, n, d);
    checks++;
    if (!o || d !== exp_word(32'h0)) begin
      errors++;
      $display("FAIL lru_touch: ok %b rdata %h want 1/%h", o, d, exp_word(32'h0));
    end
    miss_txn(1'b0, 32'h1000, 32'h0, 4'h0, o, ma, d);
    checks++;
    if (!o || ma !== 32'h1000 || d !== exp_word(32'h1000)) begin
      errors++;
      $display("FAIL lru_evict: ok %b addr %h rdata %h want 1/00001000/%h", o, ma, d, exp_word(32'h1000));
    end
    hit_txn(1'b0, 32'h0, 32'h0, 4'h0, o, n, d);
    checks++;
    if (!o || d !== exp_word(32'h0)) begin
      errors++;
      $display("FAIL lru_keep: ok %b rdata %h want 1/%h", o, d, exp_word(32'h0));
    end
    miss_txn(1'b0, 32'h404, 32'h0, 4'h0, o, ma, d);
    checks++;
    if (!o || ma !== 32'h400 || d !== exp_word(32'h404)) begin
      errors++;
      $display("FAIL lru_victim_gone: ok %b addr %h rdata %h want 1/00000400/%h", o, ma, d, exp_word(32'h404));
    end
  endtask
  task automatic test_dirty_evict(input logic [3:0] be, input logic [255:0] exp_line);
    bit o, held;
    int n;
    logic [31:0] ma, d;
    apply_reset();
    miss_txn(1'b1, 32'h0, 32'hCAFE_F00D, be, o, ma, d);
    checks++;
    if (!o || ma !== 32'h0 || d !== 32'h0) begin
      errors++;
      $display("FAIL store_miss_clean: ok %b addr %h rdata %h want 1/00000000/00000000", o, ma, d);
    end
    for (int t = 1; t < 4; t++) miss_txn(1'b0, 32'h400 * t, 32'h0, 4'h0, o, ma, d);
    send(1'b0, 32'h1000, 32'h0, 4'h0);
    wait_sig(1, o, n);
    checks++;
    if (!o || mem_addr_o !== 32'h0 || mem_read_en_o !== 1'b0 || mem_write_data_o !== exp_line) begin
      errors++;
      $display("FAIL wb_req be=%b: seen %b addr %h rd %b data %h want 1/00000000/0/%h", be, o, mem_addr_o, mem_read_en_o, mem_write_data_o, exp_line);
    end
    held = 1;
    repeat (10) begin
      @(negedge clk);
      if (mem_write_en_o !== 1'b1 || mem_read_en_o !== 1'b0) held = 0;
    end
    checks++;
    if (!held) begin
      errors++;
      $display("FAIL wb_hold: got held=%b want 1", held);
    end
    mem_write_done_i = 1'b1;
    @(negedge clk);
    mem_write_done_i = 1'b0;
    wait_sig(0, o, n);
    checks++;
    if (!o || mem_addr_o !== 32'h1000 || mem_write_en_o !== 1'b0) begin
      errors++;
      $display("FAIL wb_then_refill: seen %b addr %h wr %b want 1/00001000/0", o, mem_addr_o, mem_write_en_o);
    end
    if (o) serve_read(mk_line(32'h1000));
    wait_sig(2, o, n);
    checks++;
    if (!o || resp_rdata_o !== exp_word(32'h1000) || stat_miss_o !== 1'b1) begin
      errors++;
      $display("FAIL wb_resp: seen %b rdata %h miss %b want 1/%h/1", o, resp_rdata_o, stat_miss_o, exp_word(32'h1000));
    end
    miss_txn(1'b0, 32'h0, 32'h0, 4'h0, o, ma, d);
    checks++;
    if (!o || ma !== 32'h0) begin
      errors++;
      $display("FAIL clean_evict: ok %b addr %h want 1/00000000", o, ma);
    end
  endtask
  task automatic test_reset_mid_refill();
    bit o;
    int n;
    logic [31:0] ma, d;
    send(1'b0, 32'h2040, 32'h0, 4'h0);
    wait_sig(0, o, n);
    rst = 1'b1;
    #1;
    checks++;
    if (!o || mem_read_en_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: seen %b rd_en %b want 1/0", o, mem_read_en_o);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    serve_read(mk_line(32'h2040));
    checks++;
    if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1 || stat_miss_o !== 1'b0) begin
      errors++;
      $display("FAIL stray_read_valid: resp %b ready %b miss %b want 0/1/0", resp_valid_o, req_ready_o, stat_miss_o);
    end
    miss_txn(1'b0, 32'h2040, 32'h0, 4'h0, o, ma, d);
    checks++;
    if (!o || ma !== 32'h2040 || d !== exp_word(32'h2040)) begin
      errors++;
      $display("FAIL reset_remiss: ok %b addr %h rdata %h want 1/00002040/%h", o, ma, d, exp_word(32'h2040));
    end
  endtask
  task automatic test_back_to_back();
    bit o;
    int n;
    logic [31:0] d;
    hit_txn(1'b0, 32'h205C, 32'h0, 4'h0, o, n, d);
    checks++;
    if (!o || n !== 1 || d !== exp_word(32'h205C)) begin
      errors++;
      $display("FAIL b2b_first: ok %b lat %0d rdata %h want 1/1/%h", o, n, d, exp_word(32'h205C));
    end
    @(negedge clk);
    checks++;
    if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ready: ready %b resp %b want 1/0", req_ready_o, resp_valid_o);
    end
    {req_valid_i, req_we_i, req_addr_i} = {1'b1, 1'b0, 32'h2048};
    @(negedge clk);
    {req_valid_i, req_addr_i} = {1'b0, 32'h0};
    wait_sig(2, o, n);
    checks++;
    if (!o || n !== 1 || resp_rdata_o !== exp_word(32'h2048) || stat_hit_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second: seen %b lat %0d rdata %h want 1/1/%h", o, n, resp_rdata_o, exp_word(32'h2048));
    end
  endtask
  initial begin
    logic [255:0] l;
    test_reset();
    test_cold_miss();
    test_hit_and_store();
    test_lru();
    l = mk_line(32'h0);
    l[31:0] = 32'hCAFE_F00D;
    test_dirty_evict(4'hF, l);
    test_dirty_evict(4'h0, mk_line(32'h0));
    test_reset_mid_refill();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/set_assoc_wb_cache.md
Name: set_assoc_wb_cache

Overview:
Parametrised N-way set-associative, write-back, write-allocate data cache with byte-enabled stores.
- Sits between the RV32i pipeline load/store unit and the next memory level.
- Serves one request at a time through a valid/ready handshake.
- Handles misses with an eviction/refill state machine: dirty victim write-back first, then line refill.
- Uses true LRU replacement based on per-way age counters.

Parameters:
ByteOffsetBits, 5, byte offset width; line = 2**ByteOffsetBits bytes, must be >= 3
IndexBits, 5, set index width; NrSets = 2**IndexBits
TagBits, 22, tag width; TagBits+IndexBits+ByteOffsetBits must equal 32
NB_WAYS, 4, associativity; power of two, >= 2
(derived) BITS_WAYS = $clog2(NB_WAYS); NrWordsPerLine = 2**ByteOffsetBits/4; LineSize = 32*NrWordsPerLine

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  asynchronous, active-high reset
req_valid_i  in  1  request present
req_ready_o  out  1  cache accepts request this cycle
req_we_i  in  1  1 = store, 0 = load
req_addr_i  in  32  byte address, word-aligned; bits [1:0] ignored
req_wdata_i  in  32  store data
req_be_i  in  4  store byte enables
resp_valid_o  out  1  one-cycle pulse, request complete
resp_rdata_o  out  32  load data; 0 for stores
mem_addr_o  out  32  line-aligned address to next level
mem_read_en_o  out  1  refill request, held until mem_read_valid_i
mem_read_valid_i  in  1  refill line valid, single-cycle pulse
mem_read_data_i  in  LineSize  refill line
mem_write_en_o  out  1  write-back request, held until mem_write_done_i
mem_write_data_o  out  LineSize  victim line
mem_write_done_i  in  1  write-back accepted, single-cycle pulse
stat_hit_o  out  1  pulse on each hit completion
stat_miss_o  out  1  pulse on each miss completion

Behaviour:
- Reset (async, rst_i=1):
  - All valid and dirty bits cleared; way w of every set has age w; FSM goes to IDLE.
  - All outputs 0, except req_ready_o=1 once reset is released.
  - Tag and data arrays need not be cleared.
- FSM states: IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i, latch addr, we, wdata, be → LOOKUP.
- LOOKUP:
  - req_ready_o=0.
  - Compare the tag against all ways of the indexed set; hit = valid && tag match.
  - On hit: load reads the selected word; store merges bytes under be and sets dirty; update LRU.
  - Hit path → RESPOND, so resp_valid_o is asserted 2 cycles after acceptance.
- Miss, victim selection:
  - Victim = lowest-index invalid way; if none, the way with age NB_WAYS-1.
  - Victim dirty → WRITEBACK; otherwise → REFILL.
- WRITEBACK:
  - mem_addr_o = {victim tag, index, 0}; mem_write_data_o = victim line; mem_write_en_o=1.
  - On mem_write_done_i: clear dirty → REFILL.
- REFILL:
  - mem_addr_o = {req tag, index, 0}; mem_read_en_o=1.
  - On mem_read_valid_i: write line and tag into victim; valid=1, dirty=0.
  - For a store, merge wdata in the same cycle and set dirty=1.
  - Update LRU; set resp_rdata_o from the incoming line (bypass) → RESPOND.
- RESPOND:
  - resp_valid_o=1 for exactly one cycle → IDLE.
  - stat_hit_o or stat_miss_o pulses in the same cycle.
- LRU update on any access to way a (hit or fill):
  - age[a] ← 0; every way with age < old age[a] increments.
  - Ages in a set always form a permutation of 0..NB_WAYS-1.
- Boundary rules:
  - mem_read_valid_i or mem_write_done_i outside its own state is ignored.
  - Request inputs are sampled only at acceptance; later changes are ignored.
  - Back-to-back requests are possible: a new request may be accepted the cycle after RESPOND.
  - Reset mid-miss: the transaction is abandoned and the memory enables drop asynchronously.
  - An all-zero be store still counts as an access: LRU updates and dirty is set.
  - Store on a miss with a clean victim causes no write-back.

Decomposition:
- Package cache_pkg: cache_state_t enum, address-field slicing functions (tag/index/offset), and the parameter-derived width constants.
- Sub-module lru_age_tracker (per-set age vectors): inputs for access way, update strobe, set index; outputs victim way and an all-valid flag.
- Tag, data, valid and dirty arrays and the FSM stay in the top module.

Test Plan:
- Reset, load 0x0000_0004 (cold miss) → mem_read_en_o with mem_addr_o=0x0000_0000; refill word1=0xDEAD_BEEF → resp_rdata_o=0xDEAD_BEEF, stat_miss_o=1, no mem_write_en_o.
- Repeat load 0x0000_0004 → resp_valid_o 2 cycles after acceptance, data 0xDEAD_BEEF, stat_hit_o=1, memory enables stay 0.
- Store 0x0000_0004, wdata 0x1122_3344, be=4'b0011 → subsequent load returns 0xDEAD_3344.
- NB_WAYS=4: load tags 0..3 into set 0 (0x000, 0x400, 0x800, 0xC00), re-touch 0x000, load 0x1000.
  - Victim is 0x400, with no write-back.
  - Then load 0x000 again → hit.
- Dirty eviction: store to 0x000, fill the set, then miss in set 0.
  - mem_write_en_o with mem_addr_o=0x0000_0000 and a data line containing the stored word, before mem_read_en_o.
  - Delaying mem_write_done_i by 10 cycles holds WRITEBACK.
- Assert rst_i during REFILL → mem_read_en_o=0 immediately; after release a load of the same address misses again; a stray mem_read_valid_i in IDLE is ignored.
